// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: owns the fetch PC, turns an EX-stage taken branch
// into a redirect plus pipeline flush, enforces a one-cycle squash window
// after each redirect and keeps saturating branch statistics.
module branch_redirect_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             branch_out,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count,
    output logic             misalign_err
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(3'd4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: a counter at its ceiling stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             misalign_q, misalign_d;

    logic             live_branch_s;
    logic             taken_s;
    logic [XLEN-1:0]  target_s;

    // A branch only counts or redirects outside the squash window; the
    // instruction in EX during SQUASH is on the wrong path.
    assign live_branch_s = ex_valid & ex_branch & (state_q == ST_RUN);
    assign taken_s       = live_branch_s & branch_out & ~reset;
    assign target_s      = ex_pc + ex_imm;

    assign flush_if_id  = taken_s | reset;
    assign flush_id_ex  = taken_s | reset;
    assign pc           = pc_q;
    assign branch_count = branch_cnt_q;
    assign taken_count  = taken_cnt_q;
    assign misalign_err = misalign_q;

    // Next-state logic: FSM, PC selection (taken > stall > sequential), counters, sticky error.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        misalign_d   = misalign_q;

        case (state_q)
            ST_RUN: begin
                if (taken_s) begin
                    state_d = ST_SQUASH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SQUASH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        // The redirect wins over a concurrent stall so it is never delayed.
        if (taken_s) begin
            pc_d = target_s;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + PC_STEP;
        end

        // EX keeps advancing under a load-use stall, so stall does not gate counting.
        if (live_branch_s) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
            if (branch_out) begin
                taken_cnt_d = sat_inc(taken_cnt_q);
            end else begin
                taken_cnt_d = taken_cnt_q;
            end
        end else begin
            branch_cnt_d = branch_cnt_q;
            taken_cnt_d  = taken_cnt_q;
        end

        // The misaligned redirect still happens; only the flag records it.
        if (taken_s && (target_s[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // State register with synchronous reset that overrides any concurrent branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            branch_cnt_q <= {CNT_W{1'b0}};
            taken_cnt_q  <= {CNT_W{1'b0}};
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            misalign_q   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed scenarios followed
// by random traffic, all compared against a cycle-level reference model.
// A second instance with 4-bit counters shares the inputs to reach saturation.
module tb_branch_redirect_unit;

    logic        clk = 1'b0;
    logic        reset, stall, ex_valid, ex_branch, branch_out;
    logic [63:0] ex_pc, ex_imm;

    logic [63:0] pc_w;
    logic        fif_w, fid_w, mis_w;
    logic [31:0] bc_w, tc_w;

    logic [63:0] pc_n;
    logic        fif_n, fid_n, mis_n;
    logic [3:0]  bc_n, tc_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0]     m_pc;
    bit              m_sq;
    longint unsigned m_nb, m_nt;
    bit              m_mis;

    always #5 clk = ~clk;

    branch_redirect_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .branch_out(branch_out), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .pc(pc_w), .flush_if_id(fif_w), .flush_id_ex(fid_w),
        .branch_count(bc_w), .taken_count(tc_w), .misalign_err(mis_w)
    );

    branch_redirect_unit #(.CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .branch_out(branch_out), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .pc(pc_n), .flush_if_id(fif_n), .flush_id_ex(fid_n),
        .branch_count(bc_n), .taken_count(tc_n), .misalign_err(mis_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned n, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic drive(input bit r, input bit s, input bit v, input bit b, input bit o,
                         input logic [63:0] p, input logic [63:0] i);
        reset = r; stall = s; ex_valid = v; ex_branch = b; branch_out = o;
        ex_pc = p; ex_imm = i;
    endtask

    // One clock: check the combinational flushes, advance the model, check registered outputs.
    task automatic step();
        bit          tk;
        logic [63:0] tgt;
        #1;
        tk  = ex_valid && ex_branch && branch_out && !m_sq && !reset;
        tgt = ex_pc + ex_imm;
        chk("flush_if_id", {63'd0, fif_w}, {63'd0, reset || tk});
        chk("flush_id_ex", {63'd0, fid_w}, {63'd0, reset || tk});
        chk("flush_n",     {63'd0, fif_n & fid_n}, {63'd0, reset || tk});
        if (reset) begin
            m_pc = 64'd0; m_sq = 1'b0; m_nb = 0; m_nt = 0; m_mis = 1'b0;
        end else begin
            if (!m_sq && ex_valid && ex_branch) begin
                m_nb++;
                if (branch_out) m_nt++;
            end
            if (tk) begin
                m_pc = tgt;
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            end else if (!stall) begin
                m_pc = m_pc + 64'd4;
            end
            m_sq = tk;
        end
        @(posedge clk);
        #1;
        chk("pc",           pc_w, m_pc);
        chk("pc_n",         pc_n, m_pc);
        chk("branch_count", {32'd0, bc_w}, sat(m_nb, 32));
        chk("taken_count",  {32'd0, tc_w}, sat(m_nt, 32));
        chk("branch_cnt_n", {60'd0, bc_n}, sat(m_nb, 4));
        chk("taken_cnt_n",  {60'd0, tc_n}, sat(m_nt, 4));
        chk("misalign_err", {63'd0, mis_w}, {63'd0, m_mis});
        chk("misalign_n",   {63'd0, mis_n}, {63'd0, m_mis});
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rp, ri;
        m_pc = 64'd0; m_sq = 1'b0; m_nb = 0; m_nt = 0; m_mis = 1'b0;

        // Reset two cycles, then free-run: 4, 8, 12, 16
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        step(); step();
        chk("reset_pc_const", pc_w, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        for (int k = 0; k < 4; k++) step();
        chk("seq_pc_const", pc_w, 64'd16);

        // Taken backward branch, then the same inputs held during SQUASH
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFF0);
        step();
        chk("taken_pc_const", pc_w, 64'h30);
        step();
        chk("squash_pc_const", pc_w, 64'h34);
        chk("squash_bc_const", {32'd0, bc_w}, 64'd1);

        // Get to 0x100, then not-taken live branches under stall
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'hFC);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h100, 64'h40);
        for (int k = 0; k < 3; k++) step();
        chk("stall_hold_const", pc_w, 64'h100);

        // Taken overrides a concurrent stall
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h200, 64'h8);
        step();
        chk("taken_stall_const", pc_w, 64'h208);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();

        // Reset arriving together with a taken branch
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h500, 64'h20);
        step();
        // First cycle after reset is RUN, so a taken branch redirects at once
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h10, 64'h2);
        step();
        chk("misalign_pc_const", pc_w, 64'h12);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step(); step();
        chk("wrap_pc_const", pc_w, 64'h0);
        chk("mis_sticky_const", {63'd0, mis_w}, 64'd1);

        // Saturation of the narrow counters
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h80, 64'h10);
        for (int k = 0; k < 20; k++) step();
        chk("sat_bc_const", {60'd0, bc_n}, 64'd15);
        chk("sat_tc_const", {60'd0, tc_n}, 64'd0);
        chk("wide_bc_const", {32'd0, bc_w}, 64'd20);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rp = {$urandom, $urandom} & ~64'h3;
            ri = {{52{$urandom_range(1, 0) == 1}}, 12'($urandom_range(4095, 0))} & ~64'h1;
            if ($urandom_range(7, 0) != 0) ri = ri & ~64'h2;
            drive($urandom_range(39, 0) == 0, $urandom_range(3, 0) == 0,
                  $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                  $urandom_range(1, 0) == 1, rp, ri);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Sits directly downstream of the EX-stage branch comparator.
- Consumes the comparator's taken/not-taken result, together with the EX-stage PC and immediate.
- Owns the fetch PC register and computes the next PC; asserts the IF/ID and ID/EX flushes for a taken branch.
- Enforces a one-cycle squash window and keeps saturating branch statistics counters.

Parameters:
- XLEN, 64, datapath/PC width
- RESET_PC, 64'h0, PC value loaded on reset
- CNT_W, 32, width of statistics counters

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit PC hold (load-use)
- ex_valid  input  1  EX slot holds a live (non-bubble) instruction
- ex_branch  input  1  EX instruction is a conditional branch (ID/EX control bit)
- branch_out  input  1  comparator result: 1 = condition true
- ex_pc  input  XLEN  PC of EX-stage instruction
- ex_imm  input  XLEN  sign-extended B-type byte offset (bit0 = 0)
- pc  output  XLEN  registered fetch PC
- flush_if_id  output  1  clear IF/ID at next edge
- flush_id_ex  output  1  clear ID/EX at next edge
- branch_count  output  CNT_W  live branches resolved
- taken_count  output  CNT_W  branches taken
- misalign_err  output  1  sticky: a taken target had target[1:0] != 0

Behaviour:
- Reset is synchronous, active-high; it is sampled on the clk rising edge.
- Reset values:
  - pc = RESET_PC
  - state = RUN
  - branch_count = 0, taken_count = 0
  - misalign_err = 0
- flush_if_id and flush_id_ex are 1 while reset is high.
- Reset overrides everything in the same cycle, including a concurrent taken branch; reset mid-squash returns to RUN.
- Two-state FSM:
  - RUN -> SQUASH when taken.
  - SQUASH -> RUN unconditionally after exactly one cycle; stall does not extend it.
  - SQUASH never re-enters SQUASH.
- taken = ex_valid & ex_branch & branch_out & (state==RUN) & ~reset (combinational).
- In SQUASH, ex_branch/branch_out are ignored: no redirect, no flush, no counting.
- Next-PC priority: reset > taken > stall > sequential.
  - taken: pc <= ex_pc + ex_imm (mod 2^XLEN).
  - stall, not taken: pc holds.
  - otherwise: pc <= pc + 4 (mod 2^XLEN; wraps from all-ones-minus-3 to 0).
- Redirect latency: target appears on pc one edge after the cycle taken is high.
- flush_if_id = flush_id_ex = taken | reset, combinational, same cycle as taken.
- taken overrides stall: the redirect is not delayed by a concurrent stall.
- Counters update in RUN only; stall does not gate them, since EX advances under load-use stall.
  - ex_valid & ex_branch: branch_count +1.
  - additionally branch_out: taken_count +1.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- misalign_err sets when taken and (ex_pc+ex_imm)[1:0] != 0; the redirect still occurs. It clears only on reset.
- Non-branch or bubble in EX (ex_valid=0 or ex_branch=0): branch_out is ignored.

Test Plan:
- Reset then run: reset high 2 cycles, then low, no stalls, no branches -> pc = 0, 4, 8, 12 on successive edges; flushes high only during reset; counters 0.
- Taken branch: ex_valid=1, ex_branch=1, branch_out=1, ex_pc=0x40, ex_imm=0xFFFF_FFFF_FFFF_FFF0 -> flushes high that cycle; pc=0x30 next edge; branch_count=1, taken_count=1.
  - Following cycle, same inputs held: SQUASH ignores them -> no flush, pc=0x34, counts unchanged.
- Not taken plus stall: branch_out=0 with stall=1 for 3 cycles at pc=0x100 -> pc holds 0x100; branch_count increments each cycle (1, 2, 3); taken_count=0; no flush.
- Taken with stall: stall=1 and taken, ex_pc=0x200, ex_imm=0x8 -> pc=0x208 next edge; flushes asserted.
  - Reset asserted in a taken cycle: pc=RESET_PC, counters 0, state RUN.
- Misalign and wrap:
  - taken with ex_pc=0x10, ex_imm=0x2 -> pc=0x12, misalign_err=1, and it stays 1 through later branches until reset.
  - pc=0xFFFF_FFFF_FFFF_FFFC sequential -> pc=0.
- Saturation: CNT_W=4, 20 consecutive not-taken live branches -> branch_count stops at 15; taken_count 0.
